// File: rtl/arb_pkg.sv
// Shared types and sizing for the eight-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  // Arbiter FSM encoding. One bit is enough for the two states.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decode3_8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational.
// Backpressure: none.
module decode3_8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  // Set exactly one bit when enabled, otherwise drive zero.
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_prio_pick.sv
// Round-robin winner search: first set req bit at or after ptr, wrapping 7->0.
// Latency: combinational.
// Backpressure: none; found=0 when req is empty.
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   enc;

  // Rotate so that bit 0 of rot corresponds to req[ptr].
  assign rot = NUM_REQ'({req, req} >> ptr);

  // Fixed-priority encode on the rotated vector; lowest bit wins.
  always_comb begin
    enc   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // Undo the rotation; the 3-bit add wraps naturally modulo 8.
  assign idx = enc + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and optional hold limit.
// Latency: grant appears one cycle after a request is seen in IDLE; every release costs one idle cycle.
// Backpressure: non-owner requests are not queued; requesters must hold req until granted.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               hold_expired
);

  // Hold limit is disabled when MAX_HOLD is zero; HOLD_LAST is then unused.
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e         state_q;
  arb_state_e         state_d;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [IDX_W-1:0]   grant_idx_d;
  logic               grant_valid_d;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_d;
  logic               hold_expired_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               owner_req;
  logic               hold_hit;

  rr_prio_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // One-hot form of the candidate owner, registered into grant on acceptance.
  decode3_8 u_dec (
    .idx    (pick_idx),
    .en     (pick_found),
    .onehot (pick_onehot)
  );

  assign owner_req = req[grant_idx];
  assign hold_hit  = HOLD_EN && (hold_cnt == HOLD_LAST);

  // Next-state and next-output logic; everything holds unless a grant or release happens.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr;
    grant_d        = grant;
    grant_idx_d    = grant_idx;
    grant_valid_d  = grant_valid;
    hold_cnt_d     = hold_cnt;
    hold_expired_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // done is ignored here; only a pending request moves us on.
        if (pick_found) begin
          state_d       = ARB_BUSY;
          grant_idx_d   = pick_idx;
          grant_d       = pick_onehot;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      ARB_BUSY: begin
        if (done || !owner_req || hold_hit) begin
          state_d        = ARB_IDLE;
          grant_d        = '0;
          grant_valid_d  = 1'b0;
          ptr_d          = grant_idx + IDX_W'(1);
          hold_cnt_d     = '0;
          // Flag only releases caused purely by the hold limit.
          hold_expired_d = hold_hit && !done && owner_req;
        end else if (hold_cnt != {HOLD_W{1'b1}}) begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_d       = ARB_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      ptr          <= '0;
      grant        <= '0;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
      hold_cnt     <= '0;
      hold_expired <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr          <= ptr_d;
      grant        <= grant_d;
      grant_idx    <= grant_idx_d;
      grant_valid  <= grant_valid_d;
      hold_cnt     <= hold_cnt_d;
      hold_expired <= hold_expired_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (unlimited and MAX_HOLD=4 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       hold_expired;

  logic [7:0] req4;
  logic       done4;
  logic [7:0] grant4;
  logic [2:0] grant_idx4;
  logic       grant_valid4;
  logic       hold_expired4;

  int total;
  int bad;

  rr_arbiter8 #(.MAX_HOLD(0), .HOLD_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .hold_expired (hold_expired)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req4),
    .done         (done4),
    .grant        (grant4),
    .grant_idx    (grant_idx4),
    .grant_valid  (grant_valid4),
    .hold_expired (hold_expired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave the time just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [7:0] g, input logic [2:0] idx,
                            input logic v, input logic he);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    if (v) check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    check({tag, ".valid"}, 32'(grant_valid), 32'(v));
    check({tag, ".hexp"}, 32'(hold_expired), 32'(he));
  endtask

  task automatic check_h4(input string tag, input logic [7:0] g, input logic v, input logic he);
    check({tag, ".grant"}, 32'(grant4), 32'(g));
    check({tag, ".valid"}, 32'(grant_valid4), 32'(v));
    check({tag, ".hexp"}, 32'(hold_expired4), 32'(he));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    req4  = 8'h00;
    done4 = 1'b0;

    // Reset state
    #12;
    check_main("rst", 8'h00, 3'd0, 1'b0, 1'b0);
    check("rst.idx", 32'(grant_idx), 32'd0);
    check("rst.ptr", 32'(dut.ptr), 32'd0);
    check_h4("rst4", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_main("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single request, then done
    req = 8'h04;
    step();
    check_main("single", 8'h04, 3'd2, 1'b1, 1'b0);
    req  = 8'h00;
    done = 1'b1;
    step();
    check_main("single_rel", 8'h00, 3'd2, 1'b0, 1'b0);
    check("single_rel.idx_hold", 32'(grant_idx), 32'd2);
    check("single_rel.ptr", 32'(dut.ptr), 32'd3);
    // done in IDLE is ignored
    step();
    check_main("done_idle", 8'h00, 3'd2, 1'b0, 1'b0);
    done = 1'b0;

    // Full rotation from ptr 0 with all requesting
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
      e = 3'(k);
      done = 1'b0;
      step();
      check_main("rot_grant", 8'h01 << e, e, 1'b1, 1'b0);
      done = 1'b1;
      step();
      check_main("rot_bubble", 8'h00, e, 1'b0, 1'b0);
    end
    done = 1'b0;
    check("rot.ptr", 32'(dut.ptr), 32'd1);

    // Serve 5 to land ptr at 6, then wrap search
    req = 8'h20;
    step();
    check_main("serve5", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    step();
    check("serve5.ptr", 32'(dut.ptr), 32'd6);
    done = 1'b0;
    req  = 8'b0010_0001;
    step();
    check_main("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    check_main("wrap0_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    check_main("next5", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    step();
    done = 1'b0;
    check("next5.ptr", 32'(dut.ptr), 32'd6);

    // Owner 3 drops its request while 1 waits
    req = 8'h08;
    step();
    check_main("own3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h02;
    step();
    check_main("drop3", 8'h00, 3'd3, 1'b0, 1'b0);
    check("drop3.ptr", 32'(dut.ptr), 32'd4);
    step();
    check_main("after_drop", 8'h02, 3'd1, 1'b1, 1'b0);
    // Unlimited hold: non-owner request and long tenure do not release
    req = 8'h12;
    for (int k = 0; k < 20; k++) step();
    check_main("long_hold", 8'h02, 3'd1, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'h00;
    step();
    check_main("long_rel", 8'h00, 3'd1, 1'b0, 1'b0);
    done = 1'b0;

    // Hold limit of 4 on the second instance
    req4 = 8'h08;
    step();
    check_h4("h4_c1", 8'h08, 1'b1, 1'b0);
    check("h4.idx", 32'(grant_idx4), 32'd3);
    step();
    check_h4("h4_c2", 8'h08, 1'b1, 1'b0);
    step();
    check_h4("h4_c3", 8'h08, 1'b1, 1'b0);
    step();
    check_h4("h4_c4", 8'h08, 1'b1, 1'b0);
    step();
    check_h4("h4_expire", 8'h00, 1'b0, 1'b1);
    step();
    check_h4("h4_regrant", 8'h08, 1'b1, 1'b0);
    step();
    step();
    step();
    check_h4("h4_cnt3", 8'h08, 1'b1, 1'b0);
    // done coincides with the hold limit: normal release
    done4 = 1'b1;
    step();
    check_h4("h4_done_limit", 8'h00, 1'b0, 1'b0);
    done4 = 1'b0;
    step();
    check_h4("h4_regrant2", 8'h08, 1'b1, 1'b0);
    req4 = 8'h00;
    step();
    check_h4("h4_drop", 8'h00, 1'b0, 1'b0);
    step();
    check_h4("h4_idle", 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-grant
    req = 8'h20;
    step();
    check_main("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
    check("pre_rst.ptr", 32'(dut.ptr), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.grant", 32'(grant), 32'h00);
    check("async_rst.valid", 32'(grant_valid), 32'd0);
    check("async_rst.ptr", 32'(dut.ptr), 32'd0);
    #10;
    rst_n = 1'b1;
    step();
    check_main("post_rst", 8'h20, 3'd5, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
